// File: rtl/dmi_access_ctrl.sv
// dmi_access_ctrl: DMIACCESS data register and DMI request/response sequencer in the TCK domain.
// Optional response watchdog enabled by defining DMI_TIMEOUT_EN.
module dmi_access_ctrl #(
    parameter int ABITS          = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              tck_i,
    input  logic              trst_ni,
    input  logic              dmi_access_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    input  logic              dmi_tdi_i,
    output logic              dmi_tdo_o,
    input  logic              dmi_reset_i,
    output logic [1:0]        dmi_error_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [ABITS-1:0]  dmi_req_addr_o,
    output logic [1:0]        dmi_req_op_o,
    output logic [DATA_W-1:0] dmi_req_data_o,
    input  logic              dmi_resp_valid_i,
    output logic              dmi_resp_ready_o,
    input  logic [DATA_W-1:0] dmi_resp_data_i,
    input  logic [1:0]        dmi_resp_resp_i
);
    localparam int W = ABITS + DATA_W + 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state;
    logic [W-1:0]        dr;
    logic [ABITS-1:0]    addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          op_q;
    logic [1:0]          error_q;
    logic                req_valid;
    logic                resp_ready;
    logic                capture;
    logic                shift;
    logic                update;
    logic                busy;
    logic                resp_done;
    logic                start;
    logic                timeout;
    logic [1:0]          err_new;

`ifdef DMI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign timeout = (state == WAIT) && !dmi_resp_valid_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign dmi_tdo_o        = dr[0];
    assign dmi_error_o      = error_q;
    assign dmi_req_valid_o  = req_valid;
    assign dmi_resp_ready_o = resp_ready;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_op_o     = op_q;
    assign dmi_req_data_o   = data_q;

    // Decode TAP strobes and the error a cycle would raise (busy beats response beats timeout).
    always_comb begin
        capture   = capture_dr_i & dmi_access_i;
        shift     = shift_dr_i & dmi_access_i;
        update    = update_dr_i & dmi_access_i;
        busy      = state != IDLE;
        resp_done = (state == WAIT) && dmi_resp_valid_i;
        start     = update && !busy && error_q == 2'd0 && (dr[1:0] == 2'd1 || dr[1:0] == 2'd2);
        err_new   = (busy && (capture || update)) ? 2'd3 :
                    resp_done                     ? dmi_resp_resp_i :
                    timeout                       ? 2'd2 : 2'd0;
    end

    // Data register, sticky error and request/response FSM with registered handshake outputs.
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            state      <= IDLE;
            dr         <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= '0;
            error_q    <= '0;
            req_valid  <= 1'b0;
            resp_ready <= 1'b1;
`ifdef DMI_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            if (capture)
                dr <= {addr_q, data_q, busy ? 2'd3 : error_q};
            else if (shift)
                dr <= {dmi_tdi_i, dr[W-1:1]};
            if (dmi_reset_i)
                error_q <= 2'd0;
            else if (error_q == 2'd0)
                error_q <= err_new;
            case (state)
                IDLE: if (start) begin
                    addr_q     <= dr[W-1 -: ABITS];
                    op_q       <= dr[1:0];
                    if (dr[1:0] == 2'd2)
                        data_q <= dr[DATA_W+1:2];
                    state      <= REQ;
                    req_valid  <= 1'b1;
                    resp_ready <= 1'b0;
                end
                REQ: if (dmi_req_ready_i) begin
                    state      <= WAIT;
                    req_valid  <= 1'b0;
                    resp_ready <= 1'b1;
`ifdef DMI_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
                WAIT: begin
`ifdef DMI_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
`endif
                    if (resp_done) begin
                        if (op_q == 2'd1)
                            data_q <= dmi_resp_data_i;
                        state <= IDLE;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_access_ctrl.sv
// tb_dmi_access_ctrl: directed checks of DR scan, DMI handshake, sticky error and optional timeout.
module tb_dmi_access_ctrl;
    logic        tck = 1'b0;
    logic        trst_n = 1'b0;
    logic        dmi_access = 1'b1;
    logic        capture_dr = 1'b0;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic        dmi_tdi = 1'b0;
    logic        dmi_tdo;
    logic        dmi_reset = 1'b0;
    logic [1:0]  dmi_error;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_data = '0;
    logic [1:0]  resp_resp = '0;
    logic [40:0] dout;
    int          passed = 0;
    int          total = 0;

    dmi_access_ctrl #(.ABITS(7), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .tck_i(tck), .trst_ni(trst_n), .dmi_access_i(dmi_access),
        .capture_dr_i(capture_dr), .shift_dr_i(shift_dr), .update_dr_i(update_dr),
        .dmi_tdi_i(dmi_tdi), .dmi_tdo_o(dmi_tdo), .dmi_reset_i(dmi_reset),
        .dmi_error_o(dmi_error), .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_addr_o(req_addr), .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
        .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
        .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic scan(input logic [40:0] din, output logic [40:0] dout_v);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < 41; i++) begin
            dout_v[i] = dmi_tdo;
            dmi_tdi = din[i];
            tick();
        end
        shift_dr = 1'b0;
        dmi_tdi = 1'b0;
    endtask

    task automatic update();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        resp_valid = 1'b1;
        resp_data = d;
        resp_resp = r;
        tick();
        resp_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        trst_n = 1'b1;
        check("rst_err", dmi_error, 0);
        check("rst_valid", req_valid, 0);
        check("rst_resp_ready", resp_ready, 1);
        check("rst_tdo", dmi_tdo, 0);
        scan(41'h0, dout);
        check("rst_scan", dout, 0);

        scan({7'h10, 32'h0, 2'd1}, dout);
        dmi_access = 1'b0;
        update();
        check("noaccess_update", req_valid, 0);
        dmi_access = 1'b1;
        update();
        check("rd_valid", req_valid, 1);
        check("rd_addr", req_addr, 7'h10);
        check("rd_op", req_op, 1);
        check("rd_resp_ready_req", resp_ready, 0);
        tick();
        check("rd_valid_drop", req_valid, 0);
        check("rd_resp_ready_wait", resp_ready, 1);
        tick();
        tick();
        respond(32'hDEADBEEF, 2'd0);
        scan(41'h0, dout);
        check("rd_capture", dout, {7'h10, 32'hDEADBEEF, 2'd0});
        check("rd_err", dmi_error, 0);

        scan({7'h04, 32'h12345678, 2'd2}, dout);
        req_ready = 1'b0;
        update();
        for (int i = 0; i < 5; i++) begin
            check("wr_hold_valid", req_valid, 1);
            check("wr_hold_addr", req_addr, 7'h04);
            check("wr_hold_data", req_data, 32'h12345678);
            tick();
        end
        check("wr_op", req_op, 2);
        req_ready = 1'b1;
        check("wr_valid_pre_hs", req_valid, 1);
        tick();
        check("wr_valid_post_hs", req_valid, 0);
        respond(32'hFFFFFFFF, 2'd0);
        check("wr_err", dmi_error, 0);
        respond(32'h99999999, 2'd0);

        scan({7'h20, 32'h0, 2'd1}, dout);
        update();
        tick();
        scan({7'h11, 32'h0, 2'd1}, dout);
        check("busy_capture", dout, {7'h20, 32'h12345678, 2'd3});
        check("busy_err", dmi_error, 3);
        update();
        check("busy_update_drop", req_valid, 0);
        respond(32'hA5A5A5A5, 2'd0);
        check("busy_err_sticky", dmi_error, 3);
        update();
        check("err_update_drop", req_valid, 0);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        check("dmireset_clear", dmi_error, 0);
        update();
        check("after_clear_valid", req_valid, 1);
        check("after_clear_addr", req_addr, 7'h11);
        tick();
        respond(32'h0BADF00D, 2'd0);
        scan(41'h0, dout);
        check("after_clear_capture", dout, {7'h11, 32'h0BADF00D, 2'd0});

        scan({7'h22, 32'h0, 2'd1}, dout);
        update();
        tick();
        respond(32'h11111111, 2'd2);
        check("fail_err", dmi_error, 2);
        update();
        check("fail_update_drop", req_valid, 0);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        check("fail_clear", dmi_error, 0);
        req_ready = 1'b0;
        update();
        check("req_stall_valid", req_valid, 1);
        capture_dr = 1'b1;
        dmi_reset = 1'b1;
        tick();
        capture_dr = 1'b0;
        dmi_reset = 1'b0;
        check("reset_beats_busy", dmi_error, 0);
        check("busy_capture_op_bit0", dmi_tdo, 1);
        check("reset_no_abort", req_valid, 1);
        req_ready = 1'b1;
        tick();
        check("reset_no_abort_hs", req_valid, 0);
        respond(32'h600DCAFE, 2'd0);
        check("reset_no_abort_err", dmi_error, 0);
        scan(41'h0, dout);
        check("reset_no_abort_capture", dout, {7'h22, 32'h600DCAFE, 2'd0});

`ifdef DMI_TIMEOUT_EN
        scan({7'h33, 32'h0, 2'd1}, dout);
        update();
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("to_before", dmi_error, 0);
        tick();
        check("to_err", dmi_error, 2);
        resp_valid = 1'b1;
        resp_data = 32'hCAFEF00D;
        check("to_late_ready", resp_ready, 1);
        tick();
        resp_valid = 1'b0;
        scan(41'h0, dout);
        check("to_capture", dout, {7'h33, 32'h600DCAFE, 2'd2});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmi_access_ctrl.md
Name: dmi_access_ctrl

Overview:
- Sequences RISC-V debug spec 0.13 DMI accesses in the JTAG TCK domain.
- Owns the 41-bit DMIACCESS data register that the TAP shifts through. Turns Update-DR into a valid/ready request to the debug module, then captures the response.
- Maintains the sticky dmistat error that the TAP reports in DTMCS.
- Sits between the DMI JTAG TAP (dmi_access, capture/shift/update, tdi/tdo, dmireset) and the debug module's DMI request/response ports.

Parameters:
- ABITS, 7, DMI address width; must match the abits field the TAP reports.
- DATA_W, 32, DMI data width; fixed at 32 by the debug spec.
- TIMEOUT_CYCLES, 255, response watchdog limit in TCK cycles; used only with DMI_TIMEOUT_EN.

Ports:
- tck_i  in  1  JTAG test clock; the only clock.
- trst_ni  in  1  synchronous active-low reset, sampled on posedge tck_i.
- dmi_access_i  in  1  IR selects DMIACCESS.
- capture_dr_i  in  1  TAP in Capture-DR.
- shift_dr_i  in  1  TAP in Shift-DR.
- update_dr_i  in  1  TAP in Update-DR.
- dmi_tdi_i  in  1  serial data from TAP.
- dmi_tdo_o  out  1  serial data to TAP (DR bit 0).
- dmi_reset_i  in  1  dtmcs.dmireset pulse; clears sticky error.
- dmi_error_o  out  2  sticky error to the TAP dmistat field.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  DM accepts request.
- dmi_req_addr_o  out  ABITS  request address.
- dmi_req_op_o  out  2  1=read, 2=write.
- dmi_req_data_o  out  DATA_W  write data.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  controller accepts response.
- dmi_resp_data_i  in  DATA_W  read data.
- dmi_resp_resp_i  in  2  0=ok, 2=failed, 3=busy.

Behaviour:
- Reset, trst_ni=0 on a tck_i edge: state=IDLE; DR, addr_q, data_q and error_q all 0. All outputs are 0 except dmi_resp_ready_o (see IDLE below). Reset mid-transaction abandons the transaction silently.
- DR layout, width ABITS+DATA_W+2 (41 at defaults): [40:34] addr, [33:2] data, [1:0] op.
- Capture, capture_dr_i & dmi_access_i:
  - DR <= {addr_q, data_q, error_q}.
  - If state != IDLE: error_q <= 3 (busy, sticky) and the captured op field = 3.
- Shift, shift_dr_i & dmi_access_i: DR <= {dmi_tdi_i, DR[40:1]}.
- dmi_tdo_o = DR[0] combinationally at all times.
- Update, update_dr_i & dmi_access_i:
  - state != IDLE: error_q <= 3; the request is dropped.
  - error_q != 0: the request is dropped.
  - op=1 or 2: addr_q <= DR addr; data_q <= DR data (write only); op_q <= op; state <= REQ.
  - op=0 or 3: no action.
- FSM:
  - IDLE: dmi_req_valid_o=0. dmi_resp_ready_o=1; any response arriving here is drained and discarded.
  - REQ: dmi_req_valid_o=1 with addr/op/data stable until dmi_req_ready_i. On dmi_req_valid_o & dmi_req_ready_i -> WAIT. Valid is never withdrawn before the handshake.
  - WAIT: dmi_resp_ready_o=1. On dmi_resp_valid_i:
    - If op_q=read, data_q <= dmi_resp_data_i.
    - If dmi_resp_resp_i != 0 and error_q == 0, error_q <= dmi_resp_resp_i.
    - state <= IDLE.
- Latency:
  - Update-DR in cycle N gives dmi_req_valid_o=1 in N+1.
  - Ready sampled in cycle M gives dmi_resp_ready_o=1 from M+1.
  - A response in cycle K is visible on the next capture at K+1 or later.
- Sticky error: only dmi_reset_i clears it, and clearing does not abort an in-flight transaction.
  - When dmi_reset_i coincides with any error set, the clear wins.
  - A nonzero error_q is never overwritten by a different nonzero value.
- dmi_error_o = error_q.
- Capture, shift and update with dmi_access_i=0 leave DR and the FSM untouched.

Optional Feature:
- Macro DMI_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each cycle in WAIT.
  - On reaching TIMEOUT_CYCLES without dmi_resp_valid_i: error_q <= 2 (if 0), data_q unchanged, state <= IDLE.
  - A late response is drained in IDLE.
  - REQ is never timed out.
- Undefined: WAIT holds indefinitely; no counter logic is present.

Test Plan:
- Reset, then capture with dmi_access_i=1 and shift 41 bits -> all-zero shifted out; dmi_error_o=0; dmi_req_valid_o=0.
- Shift in addr=0x10, data=0, op=1; update; DM returns 0xDEADBEEF with resp 0 after 3 cycles -> req_valid in update+1 with addr 0x10/op 1; next capture shifts out {0x10, 0xDEADBEEF, 0}.
- Write addr=0x04, data=0x12345678, op=2, with dmi_req_ready_i held low 5 cycles -> valid held with stable addr/data for 5 cycles; handshake on cycle 6; resp 0 -> error 0.
- Capture while in WAIT -> captured op field = 3 and dmi_error_o=3. A following update with op=1 issues no request. A dmi_reset_i pulse -> error 0. A new read then proceeds.
- DM responds resp=2 to a read -> dmi_error_o=2. Later reads are dropped until dmi_reset_i. dmireset and a busy-capture in the same cycle -> error stays 0.
- DMI_TIMEOUT_EN, TIMEOUT_CYCLES=8, DM never responds -> IDLE and dmi_error_o=2 eight cycles after WAIT entry. A late response is accepted with dmi_resp_ready_o=1 and leaves data_q unchanged.
